// File: rtl/dwt_lifting_ml.sv
`default_nettype none
// ============================================================================
// Module   : dwt_lifting_ml
// Purpose  : Multi-level integer Haar wavelet transform using the lifting
//            scheme, processing one block of BLOCK_LEN samples at a time.
//            Per pair (e, o):  d = o - e ;  s = e + (d >>> 1)  (mod 2^DATA_W).
//            Level-1 details stream out while samples arrive. Coarse values
//            are kept in a BLOCK_LEN/2 buffer and refined in place for
//            levels 2..LEVELS. The final coarse values are then flushed.
// Ports    : clk        - single clock, rising edge
//            rst        - asynchronous reset, active low
//            in_valid   - in_data holds a sample
//            in_ready   - a sample is accepted this cycle
//            in_data    - signed input sample
//            out_valid  - out_data holds a coefficient
//            out_ready  - sink accepts the coefficient
//            out_data   - signed coefficient
//            out_detail - 1 = detail coefficient, 0 = final coarse value
//            out_level  - decomposition level of the coefficient
//            block_done - one-cycle pulse after a block's last coefficient
// Options  : DWT_ROUND_EN - when defined, s = e + ((d + 1) >>> 1)
// Revision : 1.0 - initial release
// ============================================================================
module dwt_lifting_ml #(
    parameter int DATA_W    = 16,
    parameter int BLOCK_LEN = 16,
    parameter int LEVELS    = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_detail,
    output logic [3:0]        out_level,
    output logic              block_done
);

    localparam int c_LOG2   = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;
    localparam int c_HALF   = (BLOCK_LEN >= 2) ? (BLOCK_LEN / 2) : 1;
    localparam int c_HALF_W = (c_HALF > 1) ? $clog2(c_HALF) : 1;

    localparam logic [c_LOG2-1:0]   c_CNT_LAST   = c_LOG2'(BLOCK_LEN - 1);
    localparam logic [c_HALF_W-1:0] c_FLUSH_LAST = c_HALF_W'((BLOCK_LEN >> LEVELS) - 1);
    localparam logic [3:0]          c_LAST_LEVEL = 4'(LEVELS);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_LOAD  = 2'd1;
    localparam logic [1:0] c_LEVEL = 2'd2;
    localparam logic [1:0] c_FLUSH = 2'd3;

    generate
        if ((BLOCK_LEN < 2) || ((BLOCK_LEN & (BLOCK_LEN - 1)) != 0) ||
            (LEVELS < 1) || (LEVELS > c_LOG2) || (LEVELS > 15) || (DATA_W < 2)) begin : g_bad_params
            $error("dwt_lifting_ml: illegal DATA_W/BLOCK_LEN/LEVELS combination");
        end
    endgenerate

    // Returns {d, s} for one lifting step, all arithmetic modulo 2^DATA_W.
    function automatic logic [2*DATA_W-1:0] lift(input logic [DATA_W-1:0] e,
                                                 input logic [DATA_W-1:0] o);
        logic signed [DATA_W-1:0] d;
        logic signed [DATA_W-1:0] u;
        logic        [DATA_W-1:0] s;
        d = o - e;
`ifdef DWT_ROUND_EN
        u = d + DATA_W'(1);
        u = u >>> 1;
`else
        u = d >>> 1;
`endif
        s = e + u;
        return {d, s};
    endfunction

    logic [1:0]          r_state;
    logic [1:0]          w_state_next;
    logic [c_LOG2-1:0]   r_cnt;        // sample index within the block
    logic [DATA_W-1:0]   r_even;       // even sample waiting for its partner
    logic [3:0]          r_level;      // level being refined in LEVEL
    logic [c_HALF_W-1:0] r_pair;       // pair index in LEVEL, read index in FLUSH
    logic                r_flush_done; // last coarse value is in the output register
    logic [DATA_W-1:0]   r_coarse [c_HALF];

    logic                w_out_free;
    logic                w_accept;
    logic                w_pair_last;
    logic                w_flush_step;
    logic                w_flush_end;
    logic [c_HALF_W-1:0] w_rd_even_idx;
    logic [c_HALF_W-1:0] w_rd_odd_idx;
    logic [2*DATA_W-1:0] w_lift_in;
    logic [2*DATA_W-1:0] w_lift_lvl;

    logic                w_emit;
    logic [DATA_W-1:0]   w_emit_data;
    logic                w_emit_detail;
    logic [3:0]          w_emit_level;
    logic                w_mem_we;
    logic [c_HALF_W-1:0] w_mem_addr;
    logic [DATA_W-1:0]   w_mem_data;

    // The output register can take a new value when empty or draining now;
    // every processing step is gated by this, so a stalled sink stalls all.
    assign w_out_free = !out_valid || out_ready;

    // Gated with rst so in_ready drops immediately while reset is held; held
    // low during the block_done cycle so the next block starts one cycle later.
    assign in_ready = rst && !block_done &&
                      ((r_state == c_IDLE) || (r_state == c_LOAD)) && w_out_free;
    assign w_accept = in_valid && in_ready;

    assign w_rd_even_idx = c_HALF_W'({r_pair, 1'b0});
    assign w_rd_odd_idx  = c_HALF_W'({r_pair, 1'b1});
    assign w_lift_in     = lift(r_even, in_data);
    assign w_lift_lvl    = lift(r_coarse[w_rd_even_idx], r_coarse[w_rd_odd_idx]);
    assign w_pair_last   = (r_pair == c_HALF_W'((BLOCK_LEN >> r_level) - 1));
    assign w_flush_step  = (r_state == c_FLUSH) && w_out_free && !r_flush_done;
    assign w_flush_end   = (r_state == c_FLUSH) && r_flush_done && out_valid && out_ready;

    // ---------------------------------------------------------------- FSM: state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------------------------------------------------------- FSM: next
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_accept) begin
                    w_state_next = c_LOAD;
                end
            end
            c_LOAD: begin
                if (w_accept && (r_cnt == c_CNT_LAST)) begin
                    w_state_next = (LEVELS > 1) ? c_LEVEL : c_FLUSH;
                end
            end
            c_LEVEL: begin
                if (w_out_free && w_pair_last && (r_level == c_LAST_LEVEL)) begin
                    w_state_next = c_FLUSH;
                end
            end
            c_FLUSH: begin
                if (w_flush_end) begin
                    w_state_next = c_IDLE;
                end
            end
            default: w_state_next = c_IDLE;
        endcase
    end

    // ---------------------------------------------------------------- FSM: outputs
    always_comb begin
        w_emit        = 1'b0;
        w_emit_data   = '0;
        w_emit_detail = 1'b1;
        w_emit_level  = 4'd1;
        w_mem_we      = 1'b0;
        w_mem_addr    = '0;
        w_mem_data    = '0;
        case (r_state)
            c_LOAD: begin
                // Odd sample completes a pair: emit d, store s at pair index.
                if (w_accept && r_cnt[0]) begin
                    w_emit      = 1'b1;
                    w_emit_data = w_lift_in[2*DATA_W-1:DATA_W];
                    w_mem_we    = 1'b1;
                    w_mem_addr  = c_HALF_W'(r_cnt >> 1);
                    w_mem_data  = w_lift_in[DATA_W-1:0];
                end
            end
            c_LEVEL: begin
                // In-place refinement: index i is written only after pairs
                // (2i, 2i+1) were read, and later reads use indices above i.
                if (w_out_free) begin
                    w_emit       = 1'b1;
                    w_emit_data  = w_lift_lvl[2*DATA_W-1:DATA_W];
                    w_emit_level = r_level;
                    w_mem_we     = 1'b1;
                    w_mem_addr   = r_pair;
                    w_mem_data   = w_lift_lvl[DATA_W-1:0];
                end
            end
            c_FLUSH: begin
                if (w_flush_step) begin
                    w_emit        = 1'b1;
                    w_emit_data   = r_coarse[r_pair];
                    w_emit_detail = 1'b0;
                    w_emit_level  = c_LAST_LEVEL;
                end
            end
            default: ;
        endcase
    end

    // ---------------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_detail   <= 1'b0;
            out_level    <= 4'd0;
            block_done   <= 1'b0;
            r_cnt        <= '0;
            r_even       <= '0;
            r_level      <= 4'd2;
            r_pair       <= '0;
            r_flush_done <= 1'b0;
        end else begin
            block_done <= w_flush_end;

            if (w_emit) begin
                out_valid  <= 1'b1;
                out_data   <= w_emit_data;
                out_detail <= w_emit_detail;
                out_level  <= w_emit_level;
            end else if (out_ready) begin
                out_valid  <= 1'b0;
            end

            case (r_state)
                c_IDLE: begin
                    r_level      <= 4'd2;
                    r_pair       <= '0;
                    r_flush_done <= 1'b0;
                    r_cnt        <= w_accept ? c_LOG2'(1) : '0;
                    if (w_accept) begin
                        r_even <= in_data;
                    end
                end
                c_LOAD: begin
                    if (w_accept) begin
                        if (!r_cnt[0]) begin
                            r_even <= in_data;
                        end
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_LEVEL: begin
                    if (w_out_free) begin
                        if (w_pair_last) begin
                            r_pair  <= '0;
                            r_level <= r_level + 4'd1;
                        end else begin
                            r_pair  <= r_pair + 1'b1;
                        end
                    end
                end
                c_FLUSH: begin
                    if (w_flush_step) begin
                        if (r_pair == c_FLUSH_LAST) begin
                            r_flush_done <= 1'b1;
                        end else begin
                            r_pair <= r_pair + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Coarse buffer: contents need no reset, every entry is written before use.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_coarse[w_mem_addr] <= w_mem_data;
        end
    end

endmodule
`default_nettype wire
